// File: rtl/axi_rd_demux_pkg.sv
// Shared types and elaboration helpers for the AXI read-return demultiplexer.
package axi_rd_demux_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } ser_state_e;

    function automatic int clog2_min1(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    function automatic int ratio(input int ddr_w, input int out_w);
        return ddr_w / out_w;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 32'sd0) && ((n & (n - 32'sd1)) == 32'sd0);
    endfunction

    // Depths of at least 2 keep the pointer index field non-empty.
    function automatic bit params_legal(input int num_ch, input int id_w, input int ddr_w,
                                        input int out_w, input int in_d, input int ch_d);
        return (out_w > 32'sd0) && ((ddr_w % out_w) == 32'sd0) && is_pow2(ddr_w / out_w) &&
               is_pow2(in_d) && (in_d >= 32'sd2) && is_pow2(ch_d) && (ch_d >= 32'sd2) &&
               (num_ch >= 32'sd2) && (num_ch <= 32'sd8) && (id_w >= 32'sd2) &&
               (num_ch <= (32'sd1 << (id_w - 32'sd1)));
    endfunction

endpackage

// File: rtl/axi_rd_demux_n_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers and an occupancy count.
module sc_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign level     = wr_ptr_r - rd_ptr_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Pointer update; pushes into a full FIFO and pops from an empty one are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/axi_rd_demux_n.sv
// Buffers AXI read beats, splits each into OUT_DWIDTH words and routes them by RID to per-channel FIFOs.
module axi_rd_demux_n
    import axi_rd_demux_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DDR_DWIDTH = 256,
    parameter int OUT_DWIDTH = 64,
    parameter int IN_DEPTH   = 32,
    parameter int CH_DEPTH   = 128,
    parameter int BURST_LEN  = 16,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ID_WIDTH-1:0]                    axi_rid,
    input  logic                                   axi_rdata_valid,
    input  logic [DDR_DWIDTH-1:0]                  axi_rdata,
    output logic [NUM_CH-1:0]                      ch_valid,
    input  logic [NUM_CH-1:0]                      ch_ready,
    output logic [NUM_CH*OUT_DWIDTH-1:0]           ch_data,
    output logic [NUM_CH-1:0]                      ch_credit_ok,
    output logic                                   in_afull,
    output logic [NUM_CH*($clog2(CH_DEPTH)+1)-1:0] ch_level,
    output logic [1:0]                             err_ovf
);
    localparam int RATIO      = ratio(DDR_DWIDTH, OUT_DWIDTH);
    localparam int CH_BITS    = clog2_min1(NUM_CH);
    localparam int CNT_W      = clog2_min1(RATIO);
    localparam int IN_W       = DDR_DWIDTH + CH_BITS;
    localparam int IN_LW      = $clog2(IN_DEPTH) + 1;
    localparam int CH_LW      = $clog2(CH_DEPTH) + 1;
    localparam int CREDIT_MIN = BURST_LEN * RATIO;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(RATIO - 1);
    localparam logic [CH_BITS:0]   NUM_CH_V  = (CH_BITS + 1)'(NUM_CH);

    if (!params_legal(NUM_CH, ID_WIDTH, DDR_DWIDTH, OUT_DWIDTH, IN_DEPTH, CH_DEPTH)) begin : g_bad_params
        $error("axi_rd_demux_n: illegal parameter combination");
    end

    logic                     in_push_s, in_pop_s, in_full_s, in_empty_s;
    logic [IN_W-1:0]          in_din_s, in_dout_s;
    logic [IN_LW-1:0]         in_level_s;

    ser_state_e               state_r;
    logic [DDR_DWIDTH-1:0]    shreg_r;
    logic [CH_BITS-1:0]       ch_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [1:0]               err_r;

    logic                     ch_bad_s, tgt_full_s, wr_ok_s, beat_done_s;
    logic [CNT_W-1:0]         sel_s;
    logic [OUT_DWIDTH-1:0]    word_s;
    logic [NUM_CH-1:0]        ch_push_s, ch_full_s, ch_empty_s;
    logic [(1<<CH_BITS)-1:0]  ch_full_pad_s;

    assign in_push_s = axi_rdata_valid && !axi_rid[ID_WIDTH-1];
    assign in_din_s  = {axi_rid[CH_BITS-1:0], axi_rdata};
    assign err_ovf   = err_r;

    sc_fifo_fwft #(.WIDTH(IN_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_push_s),
        .din   (in_din_s),
        .pop   (in_pop_s),
        .dout  (in_dout_s),
        .full  (in_full_s),
        .empty (in_empty_s),
        .level (in_level_s)
    );

    // Serializer datapath decode: target status, word select and beat completion.
    always_comb begin
        ch_full_pad_s               = '1;
        ch_full_pad_s[NUM_CH-1:0]   = ch_full_s;
        ch_bad_s    = ({1'b0, ch_r} >= NUM_CH_V);
        tgt_full_s  = ch_full_pad_s[ch_r];
        wr_ok_s     = (state_r == SPLIT) && !ch_bad_s && !tgt_full_s;
        beat_done_s = (state_r == SPLIT) && (ch_bad_s || (wr_ok_s && (cnt_r == CNT_LAST)));
        in_pop_s    = !in_empty_s && ((state_r == IDLE) || beat_done_s);
        if (MSB_FIRST) begin
            sel_s = CNT_LAST - cnt_r;
        end else begin
            sel_s = cnt_r;
        end
        word_s = shreg_r[int'(sel_s) * OUT_DWIDTH +: OUT_DWIDTH];
        ch_push_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_r == CH_BITS'(i)) begin
                ch_push_s[i] = wr_ok_s;
            end else begin
                ch_push_s[i] = 1'b0;
            end
        end
    end

    // Serializer FSM with sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            shreg_r <= '0;
            ch_r    <= '0;
            cnt_r   <= '0;
            err_r   <= 2'b00;
        end else begin
            if (in_push_s && in_full_s) begin
                err_r[0] <= 1'b1;
            end
            if ((state_r == SPLIT) && ch_bad_s) begin
                err_r[1] <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (in_pop_s) begin
                        shreg_r <= in_dout_s[DDR_DWIDTH-1:0];
                        ch_r    <= in_dout_s[IN_W-1 -: CH_BITS];
                        cnt_r   <= '0;
                        state_r <= SPLIT;
                    end
                end
                SPLIT: begin
                    if (beat_done_s) begin
                        if (in_pop_s) begin
                            shreg_r <= in_dout_s[DDR_DWIDTH-1:0];
                            ch_r    <= in_dout_s[IN_W-1 -: CH_BITS];
                            cnt_r   <= '0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (wr_ok_s) begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sc_fifo_fwft #(.WIDTH(OUT_DWIDTH), .DEPTH(CH_DEPTH)) u_ch_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (ch_push_s[g]),
            .din   (word_s),
            .pop   (ch_ready[g]),
            .dout  (ch_data[g*OUT_DWIDTH +: OUT_DWIDTH]),
            .full  (ch_full_s[g]),
            .empty (ch_empty_s[g]),
            .level (ch_level[g*CH_LW +: CH_LW])
        );
        assign ch_valid[g] = !ch_empty_s[g];
    end

    // Upstream flow-control flags, registered one cycle behind the occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_credit_ok <= '1;
            in_afull     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_credit_ok[i] <= (32'(CH_DEPTH) - 32'(ch_level[i*CH_LW +: CH_LW])) >= 32'(CREDIT_MIN);
            end
            in_afull <= (32'(IN_DEPTH) - 32'(in_level_s)) < 32'(BURST_LEN);
        end
    end

endmodule

// File: tb/tb_axi_rd_demux_n.sv
// Directed-random bench: instance A uses defaults, instance B uses 3 channels, MSB-first, 4-word channel FIFOs.
module tb_axi_rd_demux_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]   a_rid = '0, b_rid = '0;
    logic         a_vld = 1'b0, b_vld = 1'b0;
    logic [255:0] a_rdata = '0, b_rdata = '0;
    logic [3:0]   a_valid, a_ready = '0, a_credit;
    logic [2:0]   b_valid, b_ready = '0, b_credit;
    logic [255:0] a_data;
    logic [191:0] b_data;
    logic [31:0]  a_level;
    logic [8:0]   b_level;
    logic         a_afull, b_afull;
    logic [1:0]   a_err, b_err;

    axi_rd_demux_n u_a (
        .clk(clk), .rst(rst), .axi_rid(a_rid), .axi_rdata_valid(a_vld), .axi_rdata(a_rdata),
        .ch_valid(a_valid), .ch_ready(a_ready), .ch_data(a_data), .ch_credit_ok(a_credit),
        .in_afull(a_afull), .ch_level(a_level), .err_ovf(a_err)
    );

    axi_rd_demux_n #(.NUM_CH(3), .CH_DEPTH(4), .MSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst(rst), .axi_rid(b_rid), .axi_rdata_valid(b_vld), .axi_rdata(b_rdata),
        .ch_valid(b_valid), .ch_ready(b_ready), .ch_data(b_data), .ch_credit_ok(b_credit),
        .in_afull(b_afull), .ch_level(b_level), .err_ovf(b_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] qa [4][$];
    logic [63:0] qb [3][$];
    int popped_a [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < 4; i++) n += qa[i].size();
        for (int i = 0; i < 3; i++) n += qb[i].size();
        return n;
    endfunction

    // Score every pop about to happen at the next edge, then advance one cycle.
    task automatic tick();
        for (int i = 0; i < 4; i++) begin
            if (a_valid[i] && a_ready[i]) begin
                popped_a[i]++;
                if (qa[i].size() == 0) chk($sformatf("a_spurious_ch%0d", i), {63'd0, a_valid[i]}, 64'd0);
                else chk($sformatf("a_word_ch%0d", i), a_data[i*64 +: 64], qa[i].pop_front());
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (b_valid[i] && b_ready[i]) begin
                if (qb[i].size() == 0) chk($sformatf("b_spurious_ch%0d", i), {63'd0, b_valid[i]}, 64'd0);
                else chk($sformatf("b_word_ch%0d", i), b_data[i*64 +: 64], qb[i].pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input logic [3:0] rid, input logic [255:0] d);
        a_rid = rid; a_rdata = d; a_vld = 1'b1;
        if (!rid[3]) for (int k = 0; k < 4; k++) qa[rid[1:0]].push_back(d[k*64 +: 64]);
        tick();
        a_vld = 1'b0;
    endtask

    task automatic beat_b(input logic [3:0] rid, input logic [255:0] d, input bit acc);
        b_rid = rid; b_rdata = d; b_vld = 1'b1;
        if (!rid[3] && rid[1:0] != 2'd3 && acc)
            for (int k = 0; k < 4; k++) qb[rid[1:0]].push_back(d[(3-k)*64 +: 64]);
        tick();
        b_vld = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", 64'(pending()), 64'd0);
        repeat (4) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) qa[i].delete();
        for (int i = 0; i < 3; i++) qb[i].delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_a_valid"},  64'(a_valid),  64'd0);
        chk({tag, "_a_level"},  64'(a_level),  64'd0);
        chk({tag, "_a_credit"}, 64'(a_credit), 64'hf);
        chk({tag, "_a_afull"},  64'(a_afull),  64'd0);
        chk({tag, "_a_err"},    64'(a_err),    64'd0);
        chk({tag, "_b_valid"},  64'(b_valid),  64'd0);
        chk({tag, "_b_level"},  64'(b_level),  64'd0);
        chk({tag, "_b_credit"}, 64'(b_credit), 64'h7);
        chk({tag, "_b_afull"},  64'(b_afull),  64'd0);
        chk({tag, "_b_err"},    64'(b_err),    64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] inc;
        #1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_reset_state("reset");

        // Routing/order and latency on channel 2 of A.
        inc = {64'd3, 64'd2, 64'd1, 64'd0};
        a_ready = 4'b0000;
        beat_a(4'd2, inc);
        chk("lat_e0", 64'(a_valid), 64'd0);
        tick();
        chk("lat_e1", 64'(a_valid), 64'd0);
        tick();
        chk("lat_e2", 64'(a_valid), 64'h4);
        chk("lat_word0", a_data[128 +: 64], 64'd0);
        repeat (4) tick();
        chk("peak_level", 64'(a_level), 64'h0004_0000);
        a_ready = 4'b1111;
        drain(50);

        // MSB-first order on B.
        b_ready = 3'b111;
        beat_b(4'd2, inc, 1'b1);
        chk("msb_word_ch2", b_data[128 +: 64], 64'hx);
        drain(50);

        // Interleaving and discard on A.
        for (int i = 0; i < 4; i++) popped_a[i] = 0;
        beat_a(4'd0, rnd256());
        beat_a(4'd1, rnd256());
        beat_a(4'd8, rnd256());
        beat_a(4'd0, rnd256());
        beat_a(4'd3, rnd256());
        drain(100);
        chk("il_ch0", 64'(popped_a[0]), 64'd8);
        chk("il_ch1", 64'(popped_a[1]), 64'd4);
        chk("il_ch2", 64'(popped_a[2]), 64'd0);
        chk("il_ch3", 64'(popped_a[3]), 64'd4);
        chk("il_err", 64'(a_err), 64'd0);

        // Backpressure and credits on A channel 1.
        a_ready = 4'b1101;
        for (int n = 0; n < 16; n++) beat_a(4'd1, rnd256());
        repeat (80) tick();
        chk("bp_level64", 64'(a_level[15:8]), 64'd64);
        chk("bp_credit64", 64'(a_credit[1]), 64'd1);
        beat_a(4'd1, rnd256());
        repeat (10) tick();
        chk("bp_level68", 64'(a_level[15:8]), 64'd68);
        chk("bp_credit68", 64'(a_credit[1]), 64'd0);
        for (int n = 0; n < 33; n++) beat_a(4'd1, rnd256());
        repeat (200) tick();
        chk("bp_level128", 64'(a_level[15:8]), 64'd128);
        chk("bp_afull", 64'(a_afull), 64'd1);
        chk("bp_err", 64'(a_err), 64'd0);
        a_ready = 4'b1111;
        drain(1000);
        chk("bp_credit_back", 64'(a_credit), 64'hf);
        chk("bp_afull_back", 64'(a_afull), 64'd0);

        // Input almost-full threshold and overflow on B (two beats parked downstream).
        do_reset();
        b_ready = 3'b000;
        for (int n = 1; n <= 19; n++) begin
            beat_b(4'd0, rnd256(), 1'b1);
            repeat (8) tick();
            chk($sformatf("afull_n%0d", n), 64'(b_afull), 64'(n >= 19));
        end
        for (int n = 20; n <= 38; n++) begin
            beat_b(4'd0, rnd256(), n <= 34);
            chk($sformatf("ovf_n%0d", n), 64'(b_err[0]), 64'(n >= 35));
        end
        repeat (5) tick();
        chk("ovf_sticky", 64'(b_err), 64'd1);
        b_ready = 3'b111;
        drain(1000);
        chk("ovf_sticky_drained", 64'(b_err[0]), 64'd1);

        // Bad channel index on B.
        do_reset();
        chk("bad_cleared", 64'(b_err), 64'd0);
        beat_b(4'd3, rnd256(), 1'b1);
        repeat (10) tick();
        chk("bad_err", 64'(b_err), 64'd2);
        chk("bad_nowrite", 64'(b_valid), 64'd0);
        beat_b(4'd1, rnd256(), 1'b1);
        drain(50);

        // Reset in the middle of a split on B.
        b_ready = 3'b000;
        beat_b(4'd0, rnd256(), 1'b1);
        beat_b(4'd1, rnd256(), 1'b1);
        beat_b(4'd2, rnd256(), 1'b1);
        tick();
        do_reset();
        chk_reset_state("midrst");
        b_ready = 3'b111;
        beat_b(4'd1, rnd256(), 1'b1);
        repeat (2) tick();
        chk("midrst_route", 64'(b_valid), 64'd2);
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
